// File: rtl/tile_fetch_rd.sv
`default_nettype none
// ============================================================================
// Module   : tile_fetch_rd
// Purpose  : AXI4 read master fetching a rectangular feature tile from DDR
//            row by row into on-chip feature memory, one burst at a time.
// Revision : 1.0 - initial release
// ============================================================================
module tile_fetch_rd #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int M_AXI_DATA_BW      = 128,
    parameter int TILE_SIZE_BW       = 16,
    parameter int BOUNDARY_SIZE      = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
    input  logic [TILE_SIZE_BW-1:0]       row_len,
    input  logic [TILE_SIZE_BW-1:0]       row_count,
    input  logic [TILE_SIZE_BW-1:0]       row_stride,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic [M_AXI_DATA_BW-1:0]      m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    output logic                          oc_we,
    output logic [TILE_SIZE_BW-1:0]       oc_addr_x,
    output logic [TILE_SIZE_BW-1:0]       oc_addr_y,
    output logic [M_AXI_DATA_BW-1:0]      oc_wdata
);

    localparam int c_aw = C_M_AXI_ADDR_WIDTH;
    localparam int c_tw = TILE_SIZE_BW;
    localparam int c_bw = BOUNDARY_SIZE - 4;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_ar   = 2'd1;
    localparam logic [1:0] c_st_r    = 2'd2;
    localparam logic [1:0] c_st_fin  = 2'd3;

    localparam logic [c_bw:0] c_bnd_beats = {1'b1, {c_bw{1'b0}}};

    logic [1:0]               r_state;
    logic [c_aw-1:0]          r_row_base;
    logic [c_aw-1:0]          r_addr;
    logic [c_tw-1:0]          r_row_len;
    logic [c_tw-1:0]          r_row_count;
    logic [c_tw-1:0]          r_row_stride;
    logic [c_tw-1:0]          r_row;
    logic [c_tw-1:0]          r_col;
    logic [8:0]               r_beats;
    logic [8:0]               r_bcnt;
    logic                     r_done;
    logic                     r_err;
    logic                     r_oc_we;
    logic [c_tw-1:0]          r_oc_x;
    logic [c_tw-1:0]          r_oc_y;
    logic [M_AXI_DATA_BW-1:0] r_oc_wdata;

    logic [c_tw-1:0] w_rem;
    logic [c_bw:0]   w_bnd;
    logic [8:0]      w_bnd_cap;
    logic [8:0]      w_beats;
    logic [c_aw-1:0] w_stride_bytes;
    logic [c_aw-1:0] w_burst_bytes;
    logic [c_aw-1:0] w_next_row;
    logic            w_last_beat;
    logic            w_row_end;
    logic            w_tile_end;

    // Burst length: rest of the row, clipped at the next 4 KB line and at 256 beats.
    assign w_rem          = r_row_len - r_col;
    assign w_bnd          = c_bnd_beats - {1'b0, r_addr[BOUNDARY_SIZE-1:4]};
    assign w_bnd_cap      = (32'(w_bnd) > 32'd256) ? 9'd256 : 9'(w_bnd);
    assign w_beats        = (32'(w_rem) < 32'(w_bnd_cap)) ? 9'(w_rem) : w_bnd_cap;

    assign w_stride_bytes = c_aw'({r_row_stride, 4'b0000});
    assign w_burst_bytes  = c_aw'({r_beats, 4'b0000});
    assign w_next_row     = r_row_base + w_stride_bytes;

    // Bursts end on the counted beat; rlast is only cross-checked.
    assign w_last_beat    = (r_bcnt == (r_beats - 9'd1));
    assign w_row_end      = ((r_col + c_tw'(1)) == r_row_len);
    assign w_tile_end     = ((r_row + c_tw'(1)) >= r_row_count);

    assign busy          = (r_state != c_st_idle);
    assign done          = r_done;
    assign err           = r_err;
    assign m_axi_arvalid = (r_state == c_st_ar);
    assign m_axi_araddr  = m_axi_arvalid ? r_addr : '0;
    assign m_axi_arlen   = m_axi_arvalid ? 8'(w_beats - 9'd1) : 8'd0;
    assign m_axi_rready  = (r_state == c_st_r);
    assign oc_we         = r_oc_we;
    assign oc_addr_x     = r_oc_x;
    assign oc_addr_y     = r_oc_y;
    assign oc_wdata      = r_oc_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_row_base   <= '0;
            r_addr       <= '0;
            r_row_len    <= '0;
            r_row_count  <= '0;
            r_row_stride <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_beats      <= '0;
            r_bcnt       <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_oc_we      <= 1'b0;
            r_oc_x       <= '0;
            r_oc_y       <= '0;
            r_oc_wdata   <= '0;
        end else begin
            r_oc_we <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_err        <= 1'b0;
                        r_row_len    <= row_len;
                        r_row_count  <= row_count;
                        r_row_stride <= row_stride;
                        r_row        <= '0;
                        r_col        <= '0;
                        r_row_base   <= base_addr & {{(c_aw-4){1'b1}}, 4'b0000};
                        r_addr       <= base_addr & {{(c_aw-4){1'b1}}, 4'b0000};
                        if ((row_len != '0) && (row_count != '0)) begin
                            r_state <= c_st_ar;
                        end else begin
                            r_state <= c_st_fin;
                        end
                    end
                end
                c_st_ar: begin
                    if (m_axi_arready) begin
                        r_beats <= w_beats;
                        r_bcnt  <= '0;
                        r_state <= c_st_r;
                    end
                end
                c_st_r: begin
                    if (m_axi_rvalid) begin
                        r_oc_we    <= 1'b1;
                        r_oc_x     <= r_col;
                        r_oc_y     <= r_row;
                        r_oc_wdata <= m_axi_rdata;
                        r_col      <= r_col + c_tw'(1);
                        r_bcnt     <= r_bcnt + 9'd1;
                        if (m_axi_rresp != 2'b00) begin
                            r_err <= 1'b1;
                        end
                        if (w_last_beat) begin
                            if (!m_axi_rlast) begin
                                r_err <= 1'b1;
                            end
                            if (w_row_end) begin
                                r_row      <= r_row + c_tw'(1);
                                r_col      <= '0;
                                r_row_base <= w_next_row;
                                r_addr     <= w_next_row;
                                if (w_tile_end) begin
                                    r_state <= c_st_fin;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state <= c_st_ar;
                                end
                            end else begin
                                r_addr  <= r_addr + w_burst_bytes;
                                r_state <= c_st_ar;
                            end
                        end else if (m_axi_rlast) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    // A zero-size tile enters here without done set and pulses it one cycle later.
                    if (r_done) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tile_fetch_rd.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_fetch_rd
// Purpose  : Scoreboard bench for tile_fetch_rd with a small AXI read slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_fetch_rd;

    localparam int AW = 32;
    localparam int DW = 128;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [TW-1:0] row_len;
    logic [TW-1:0] row_count;
    logic [TW-1:0] row_stride;
    logic          busy;
    logic          done;
    logic          err;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast;
    logic          oc_we;
    logic [TW-1:0] oc_addr_x;
    logic [TW-1:0] oc_addr_y;
    logic [DW-1:0] oc_wdata;

    always #5 clk = ~clk;

    tile_fetch_rd dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .row_len       (row_len),
        .row_count     (row_count),
        .row_stride    (row_stride),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .oc_we         (oc_we),
        .oc_addr_x     (oc_addr_x),
        .oc_addr_y     (oc_addr_y),
        .oc_wdata      (oc_wdata)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } ar_t;

    typedef struct packed {
        logic [TW-1:0] x;
        logic [TW-1:0] y;
        logic [DW-1:0] data;
    } oc_t;

    ar_t exp_ar[$];
    oc_t exp_oc[$];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int oc_cnt = 0;
    bit we_with_done = 1'b1;

    // Slave configuration and state
    int            cfg_ar_stall = 0;
    bit            cfg_toggle = 1'b0;
    int            cfg_resp_beat = -1;
    int            cfg_early_burst = -1;
    bit            s_phase;
    logic [AW-1:0] s_addr;
    int            s_len;
    int            s_beat;
    int            s_burst = 0;
    int            s_gbeat = 0;
    int            stall_left;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] beat_data(logic [AW-1:0] a);
        return {a, ~a, a + 32'h1234_5678, a ^ 32'hA5A5_5A5A};
    endfunction

    task automatic push_ar(logic [AW-1:0] a, logic [7:0] l);
        exp_ar.push_back({a, l});
    endtask

    task automatic push_row(int y, logic [AW-1:0] row_addr, int n);
        for (int x = 0; x < n; x++) begin
            exp_oc.push_back({TW'(x), TW'(y), beat_data(row_addr + AW'(x * 16))});
        end
    endtask

    task automatic drive_beat();
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = beat_data(s_addr + AW'(s_beat * 16));
        m_axi_rresp  = (s_gbeat == cfg_resp_beat) ? 2'd2 : 2'd0;
        if (s_burst == cfg_early_burst) m_axi_rlast = (s_beat == s_len - 1);
        else                            m_axi_rlast = (s_beat == s_len);
    endtask

    // AXI read slave: samples on the falling edge, drives just after the rising edge.
    initial begin : slave
        bit            ar_hs;
        bit            r_hs;
        bit            rst_s;
        logic [AW-1:0] ar_a;
        logic [7:0]    ar_l;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'd0;
        m_axi_rlast   = 1'b0;
        s_phase       = 1'b0;
        stall_left    = 0;
        forever begin
            @(negedge clk);
            ar_hs = m_axi_arvalid && m_axi_arready;
            r_hs  = m_axi_rvalid && m_axi_rready;
            rst_s = rst;
            ar_a  = m_axi_araddr;
            ar_l  = m_axi_arlen;
            @(posedge clk);
            #2;
            if (rst_s) begin
                s_phase       = 1'b0;
                m_axi_arready = 1'b0;
                m_axi_rvalid  = 1'b0;
                m_axi_rlast   = 1'b0;
                m_axi_rresp   = 2'd0;
                stall_left    = cfg_ar_stall;
            end else if (!s_phase) begin
                if (ar_hs) begin
                    s_phase       = 1'b1;
                    s_addr        = ar_a;
                    s_len         = int'(ar_l);
                    s_beat        = 0;
                    m_axi_arready = 1'b0;
                    stall_left    = cfg_ar_stall;
                    drive_beat();
                end else if (m_axi_arvalid) begin
                    if (stall_left > 0) begin
                        stall_left    = stall_left - 1;
                        m_axi_arready = 1'b0;
                    end else begin
                        m_axi_arready = 1'b1;
                    end
                end else begin
                    m_axi_arready = 1'b0;
                end
            end else begin
                if (r_hs) begin
                    s_beat  = s_beat + 1;
                    s_gbeat = s_gbeat + 1;
                end
                if (s_beat > s_len) begin
                    s_phase      = 1'b0;
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                    m_axi_rresp  = 2'd0;
                    s_burst      = s_burst + 1;
                end else if (cfg_toggle && m_axi_rvalid) begin
                    m_axi_rvalid = 1'b0;
                end else begin
                    drive_beat();
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an AR handshake or an oc write.
    bit            prev_stall = 1'b0;
    bit            prev_rhs = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [7:0]    prev_len;

    initial begin : monitor
        ar_t ea;
        oc_t eo;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("ar_r_exclusive", m_axi_arvalid && m_axi_rready, 1'b0);
                chk("oc_we_latency", oc_we, prev_rhs);
                if (prev_stall && m_axi_arvalid) begin
                    chk("araddr_stable", m_axi_araddr, prev_addr);
                    chk("arlen_stable", m_axi_arlen, prev_len);
                end
                if (m_axi_arvalid && m_axi_arready) begin
                    chk("ar_expected", exp_ar.size() != 0, 1'b1);
                    if (exp_ar.size() != 0) begin
                        ea = exp_ar.pop_front();
                        chk("ar_addr", m_axi_araddr, ea.addr);
                        chk("ar_len", m_axi_arlen, ea.len);
                    end
                end
                if (oc_we) begin
                    oc_cnt = oc_cnt + 1;
                    chk("oc_expected", exp_oc.size() != 0, 1'b1);
                    if (exp_oc.size() != 0) begin
                        eo = exp_oc.pop_front();
                        chk("oc_x", oc_addr_x, eo.x);
                        chk("oc_y", oc_addr_y, eo.y);
                        chk("oc_data", oc_wdata, eo.data);
                    end
                end
                if (done) begin
                    done_cnt = done_cnt + 1;
                    chk("done_with_we", oc_we, we_with_done);
                end
                prev_stall = m_axi_arvalid && !m_axi_arready;
                prev_rhs   = m_axi_rvalid && m_axi_rready;
                prev_addr  = m_axi_araddr;
                prev_len   = m_axi_arlen;
            end else begin
                prev_stall = 1'b0;
                prev_rhs   = 1'b0;
            end
        end
    end

    task automatic check_idle_outputs(string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_arvalid"}, m_axi_arvalid, 1'b0);
        chk({tag, "_araddr"}, m_axi_araddr, '0);
        chk({tag, "_arlen"}, m_axi_arlen, '0);
        chk({tag, "_rready"}, m_axi_rready, 1'b0);
        chk({tag, "_oc_we"}, oc_we, 1'b0);
        chk({tag, "_oc_x"}, oc_addr_x, '0);
        chk({tag, "_oc_y"}, oc_addr_y, '0);
        chk({tag, "_oc_wdata"}, oc_wdata, '0);
    endtask

    // Issues one tile; caller has already pushed the expected ARs and oc writes.
    task automatic run_tile(logic [AW-1:0] b, int rl, int rc, int rs, int budget, bit exp_err);
        int  n;
        bit  zero;
        zero = (rl == 0) || (rc == 0);
        we_with_done = !zero;
        @(posedge clk);
        #1;
        done_cnt   = 0;
        s_burst    = 0;
        s_gbeat    = 0;
        start      = 1'b1;
        base_addr  = b;
        row_len    = TW'(rl);
        row_count  = TW'(rc);
        row_stride = TW'(rs);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_c1", busy, 1'b1);
        chk("arvalid_c1", m_axi_arvalid, !zero);
        chk("err_c1", err, 1'b0);
        if (zero) begin
            chk("zero_done_c1", done, 1'b0);
            @(negedge clk);
            chk("zero_done_c2", done, 1'b1);
        end else begin
            n = 0;
            while (!done && n < budget) begin
                @(negedge clk);
                n++;
            end
            chk("done_in_budget", done, 1'b1);
        end
        chk("busy_at_done", busy, 1'b1);
        @(negedge clk);
        chk("busy_after_done", busy, 1'b0);
        chk("done_one_cycle", done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("done_count", done_cnt, 1);
        chk("ar_left", exp_ar.size(), 0);
        chk("oc_left", exp_oc.size(), 0);
        chk("err_final", err, exp_err);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        row_len    = '0;
        row_count  = '0;
        row_stride = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // Two rows, one burst each
        push_ar(32'h0000_1000, 8'd7);
        push_ar(32'h0000_1100, 8'd7);
        push_row(0, 32'h0000_1000, 8);
        push_row(1, 32'h0000_1100, 8);
        run_tile(32'h0000_1000, 8, 2, 16, 200, 1'b0);

        // Row straddling a 4 KB line
        push_ar(32'h0000_1F80, 8'd7);
        push_ar(32'h0000_2000, 8'd7);
        push_row(0, 32'h0000_1F80, 16);
        run_tile(32'h0000_1F80, 16, 1, 16, 200, 1'b0);

        // Row longer than one maximal burst
        push_ar(32'h0000_0000, 8'd255);
        push_ar(32'h0000_1000, 8'd43);
        push_row(0, 32'h0000_0000, 300);
        run_tile(32'h0000_0000, 300, 1, 300, 1000, 1'b0);

        // Back-pressure on AR and sparse R beats
        cfg_ar_stall = 5;
        cfg_toggle   = 1'b1;
        push_ar(32'h0000_2000, 8'd3);
        push_ar(32'h0000_2080, 8'd3);
        push_row(0, 32'h0000_2000, 4);
        push_row(1, 32'h0000_2080, 4);
        run_tile(32'h0000_2000, 4, 2, 8, 300, 1'b0);
        cfg_ar_stall = 0;
        cfg_toggle   = 1'b0;

        // Bad rresp on beat 3, early rlast in the second burst
        cfg_resp_beat   = 3;
        cfg_early_burst = 1;
        push_ar(32'h0000_3000, 8'd7);
        push_ar(32'h0000_3080, 8'd7);
        push_row(0, 32'h0000_3000, 8);
        push_row(1, 32'h0000_3080, 8);
        run_tile(32'h0000_3000, 8, 2, 8, 200, 1'b1);
        cfg_resp_beat   = -1;
        cfg_early_burst = -1;
        repeat (3) @(negedge clk);
        chk("err_sticky", err, 1'b1);

        // A clean tile clears the sticky error (low base bits ignored)
        push_ar(32'h0000_4000, 8'd1);
        push_row(0, 32'h0000_4000, 2);
        run_tile(32'h0000_400F, 2, 1, 2, 100, 1'b0);

        // Reset in the middle of a burst
        push_ar(32'h0000_5000, 8'd31);
        push_row(0, 32'h0000_5000, 32);
        @(posedge clk);
        #1;
        oc_cnt       = 0;
        we_with_done = 1'b1;
        start        = 1'b1;
        base_addr    = 32'h0000_5000;
        row_len      = TW'(32);
        row_count    = TW'(1);
        row_stride   = TW'(32);
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (oc_cnt < 5 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("pre_reset_beats", oc_cnt >= 5, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("midrst");
        exp_ar.delete();
        exp_oc.delete();
        repeat (3) @(negedge clk);

        // Zero-size tile after reset: done only, no AR
        run_tile(32'h0000_6000, 4, 0, 4, 20, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tile_fetch_rd.md
# tile_fetch_rd

AXI4 read master that fetches a rectangular input-feature tile from DDR and writes it beat-by-beat into on-chip feature memory. It is the read-side counterpart of the layer output writer: it walks a tile row by row, splits each row into INCR bursts that never cross a 4 KB boundary, and presents each returned 128-bit beat with its (x, y) on-chip address. It sits between the master control and the input-feature bank, started once per tile.

## Interface
- C_M_AXI_ADDR_WIDTH, 32, AXI address width
- M_AXI_DATA_BW, 128, data width; one beat = 16 bytes
- TILE_SIZE_BW, 16, width of size/stride/coordinate fields
- BOUNDARY_SIZE, 12, log2 of burst boundary in bytes (4 KB)

- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- start  in  1  one-cycle pulse; latches tile parameters
- base_addr  in  C_M_AXI_ADDR_WIDTH  byte address of tile row 0, beat 0; bits [3:0] ignored
- row_len  in  TILE_SIZE_BW  beats per row
- row_count  in  TILE_SIZE_BW  rows in tile
- row_stride  in  TILE_SIZE_BW  beats between consecutive row starts in DDR
- busy  out  1  high from cycle after start until done
- done  out  1  one-cycle pulse, tile complete
- err  out  1  sticky; cleared by rst or accepted start
- m_axi_arvalid / m_axi_arready  out / in  1  AR handshake
- m_axi_araddr  out  C_M_AXI_ADDR_WIDTH  burst start address, 16-byte aligned
- m_axi_arlen  out  8  beats-1
- m_axi_rvalid / m_axi_rready  in / out  1  R handshake
- m_axi_rdata  in  M_AXI_DATA_BW  read data
- m_axi_rresp  in  2  response
- m_axi_rlast  in  1  last beat of burst
- oc_we  out  1  on-chip write strobe
- oc_addr_x  out  TILE_SIZE_BW  beat index within row
- oc_addr_y  out  TILE_SIZE_BW  row index
- oc_wdata  out  M_AXI_DATA_BW  registered rdata

## Operation
- States: IDLE, AR, R, FIN. Reset -> IDLE; all outputs 0.
- IDLE: start with row_len!=0 and row_count!=0 -> latch inputs, clear err, row=0, col=0, -> AR. start with either zero -> FIN (no AR issued). start while busy ignored.
- AR: arvalid=1; araddr, arlen stable until arready. On handshake -> R.
- Burst length: rem = row_len - col; bnd = 256 - araddr[11:4]; beats = min(rem, bnd); arlen = beats-1 (max 255).
- R: rready=1. Each accepted beat: oc_we/oc_addr_x=col/oc_addr_y=row/oc_wdata=rdata registered, col++. After the burst's counted last beat: if col==row_len then row++, col=0, next araddr = base + row*row_stride*16; else next araddr = araddr + beats*16. Then -> AR if row<row_count, else -> FIN.
- FIN: done=1 for one cycle, -> IDLE.
- Beat counting, not rlast, terminates bursts. rlast mismatch with counted last beat, or rresp!=0 on any beat, sets err; transfer continues to completion.
- Address arithmetic modulo 2^C_M_AXI_ADDR_WIDTH; araddr[3:0] always 0. Products computed at full address width.
- rst mid-operation: next edge returns to IDLE, all outputs 0, rready 0; in-flight bus data is not drained (interconnect reset together with block).

## Timing
- start at cycle 0 -> busy and arvalid high at cycle 1.
- AR handshake at cycle n -> rready high at n+1.
- R beat accepted at cycle m -> oc_we high at m+1 (one-cycle latency, exactly one oc_we per beat).
- Last beat of a non-final burst at cycle m -> arvalid high at m+1 (one bubble).
- Last beat of tile at cycle m -> oc_we and done both high at m+1; busy low at m+2.
- Zero-size start at cycle 0 -> done at cycle 2, no AR.
- One burst outstanding at a time; arvalid never high while rready high.

## Test plan
- base 0x1000, row_len 8, row_count 2, stride 16 -> AR 0x1000 len 7, AR 0x1100 len 7; 16 oc writes, x 0..7 for y=0 then y=1; done once, err=0.
- base 0x1F80, row_len 16, row_count 1 -> AR 0x1F80 len 7, AR 0x2000 len 7; x 0..15 contiguous.
- base 0x0, row_len 300, row_count 1 -> AR 0x0 len 255, AR 0x1000 len 43.
- arready low 5 cycles, rvalid toggling every other cycle -> araddr/arlen stable while stalled; oc_we only one cycle after handshakes; x contiguous, no skips.
- rresp=2 on beat 3, then rlast asserted one beat early in a later burst -> err=1 sticky, all beats still written, done asserted; next start clears err.
- rst asserted mid-burst -> next cycle all outputs 0, state IDLE; subsequent start with row_count=0 -> done at cycle 2, no AR.
